// File: rtl/add_sub_pkg.sv
// Shared types for the multi-cycle adder/subtractor: operation codes, FSM states
// and small op-decode helpers.
package add_sub_pkg;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_ACC_ADD, OP_ACC_SUB} op_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic is_sub(op_t o);
        return (o == OP_SUB) || (o == OP_ACC_SUB);
    endfunction

    function automatic logic is_acc(op_t o);
        return (o == OP_ACC_ADD) || (o == OP_ACC_SUB);
    endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// Combinational K-bit add/sub slice; msb_cin is the carry into the top bit so the
// caller can derive signed overflow as msb_cin ^ cout on the final chunk.
module add_sub_chunk #(
    parameter int K = 2
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         cin,
    input  logic         inv_b,
    output logic [K-1:0] s,
    output logic         cout,
    output logic         msb_cin
);

    logic [K-1:0] b_eff;

    assign b_eff         = inv_b ? ~b : b;
    assign {cout, s}     = {1'b0, a} + {1'b0, b_eff} + (K+1)'(cin);
    assign msb_cin       = s[K-1] ^ a[K-1] ^ b_eff[K-1];

endmodule

// File: rtl/add_sub_seq.sv
// Multi-cycle W-bit adder/subtractor built around one K-bit slice, with
// valid/ready handshakes, an accumulator and carry/overflow/zero flags.
module add_sub_seq
    import add_sub_pkg::*;
#(
    parameter int W = 8,
    parameter int K = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         acc_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] S,
    output logic         Cout,
    output logic         Ovf,
    output logic         Zero,
    output logic [W-1:0] acc
);

    localparam int NCH = W / K;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    if ((K < 1) || (W % K != 0)) begin : g_bad_param
        $error("add_sub_seq: W must be a non-zero multiple of K");
    end

    state_t         state, state_nxt;
    op_t            op_q;
    logic [W-1:0]   lhs_q, rhs_q, s_q, acc_q, s_nxt;
    logic [CW-1:0]  cnt_q;
    logic           carry_q, cout_q, ovf_q, zero_q;
    logic [K-1:0]   ch_s;
    logic           ch_cout, ch_msb_cin;
    logic           last;

    assign last = (cnt_q == CW'(NCH - 1));

    // Operands shift right so the active chunk is always in the low K bits;
    // results shift in from the top and land in place after NCH cycles.
    add_sub_chunk #(.K(K)) u_chunk (
        .a       (lhs_q[K-1:0]),
        .b       (rhs_q[K-1:0]),
        .cin     (carry_q),
        .inv_b   (is_sub(op_q)),
        .s       (ch_s),
        .cout    (ch_cout),
        .msb_cin (ch_msb_cin)
    );

    assign s_nxt = (W'(ch_s) << (W - K)) | (s_q >> K);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_ADD;
            lhs_q   <= '0;
            rhs_q   <= '0;
            s_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= op_t'(op);
                        lhs_q   <= is_acc(op_t'(op)) ? acc_q : A;
                        rhs_q   <= B;
                        cnt_q   <= '0;
                        carry_q <= is_sub(op_t'(op));
                    end else if (acc_clr) begin
                        acc_q <= '0;
                    end
                end
                RUN: begin
                    lhs_q   <= lhs_q >> K;
                    rhs_q   <= rhs_q >> K;
                    s_q     <= s_nxt;
                    carry_q <= ch_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last) begin
                        // Subtract carry is "no borrow", so invert it to report borrow.
                        cout_q <= ch_cout ^ is_sub(op_q);
                        ovf_q  <= ch_msb_cin ^ ch_cout;
                        zero_q <= (s_nxt == '0);
                        if (is_acc(op_q)) acc_q <= s_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign S         = s_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;
    assign Zero      = zero_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_add_sub_seq.sv
// Scoreboard bench for add_sub_seq (W=8, K=2): driver pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_add_sub_seq;
    import add_sub_pkg::*;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       v;
        logic       z;
        logic [7:0] acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] op = 2'b00;
    logic [7:0] A = '0, B = '0;
    logic       acc_clr = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] S, acc;
    logic       Cout, Ovf, Zero;

    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];
    logic [7:0] m_acc = '0;

    always #5 clk = ~clk;

    add_sub_seq #(.W(8), .K(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .A(A), .B(B), .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .Cout(Cout), .Ovf(Ovf), .Zero(Zero), .acc(acc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] s, input logic c, input logic v,
                                input logic z, input logic [7:0] a);
        exp_t e;
        e.s = s; e.c = c; e.v = v; e.z = z; e.acc = a;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual S=%0h required none", S);
            end else begin
                e = sbq.pop_front();
                chk("result_S",    32'(S),    32'(e.s));
                chk("result_Cout", 32'(Cout), 32'(e.c));
                chk("result_Ovf",  32'(Ovf),  32'(e.v));
                chk("result_Zero", 32'(Zero), 32'(e.z));
                chk("result_acc",  32'(acc),  32'(e.acc));
            end
        end
    end

    // hold>0: keep out_ready low that many cycles in DONE while poking the block
    // with a competing operand and acc_clr, both of which must be ignored.
    task automatic run_op(input op_t o, input logic [7:0] a, input logic [7:0] b,
                          input exp_t e, input int hold);
        int lat;
        sbq.push_back(e);
        if (hold > 0) out_ready = 1'b0;
        op = o; A = a; B = b; in_valid = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = n; break; end
        end
        chk("latency", 32'(lat), 32'd4);
        if (hold > 0) begin
            op = OP_SUB; A = 8'h01; B = 8'h02; in_valid = 1'b1; acc_clr = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("hold_S",        32'(S),         32'(e.s));
                chk("hold_Cout",     32'(Cout),      32'(e.c));
                chk("hold_in_ready", 32'(in_ready),  32'd0);
                chk("hold_valid",    32'(out_valid), 32'd1);
                chk("hold_acc",      32'(acc),       32'(e.acc));
            end
            in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic rand_op(input op_t o, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        logic       v;
        r = (o == OP_SUB) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        v = (o == OP_SUB) ? ((a[7] != b[7]) && (r[7] != a[7]))
                          : ((a[7] == b[7]) && (r[7] != a[7]));
        run_op(o, a, b, mk(r[7:0], r[8], v, r[7:0] == 8'h00, m_acc), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_S",         32'(S),         32'd0);
        chk("rst_flags",     32'({Cout, Ovf, Zero}), 32'd0);
        chk("rst_acc",       32'(acc),       32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(OP_ADD, 8'd200, 8'd100, mk(8'd44,  1, 0, 0, 8'd0), 0);
        run_op(OP_SUB, 8'd5,   8'd9,   mk(8'hFC,  1, 0, 0, 8'd0), 0);
        run_op(OP_SUB, 8'd7,   8'd7,   mk(8'h00,  0, 0, 1, 8'd0), 0);
        run_op(OP_ADD, 8'd100, 8'd100, mk(8'hC8,  0, 1, 0, 8'd0), 0);
        run_op(OP_SUB, 8'h80,  8'h01,  mk(8'h7F,  0, 1, 0, 8'd0), 0);

        run_op(OP_ACC_ADD, 8'hFF, 8'd50, mk(8'd50, 0, 0, 0, 8'd50), 0);
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        chk("acc_clr", 32'(acc), 32'd0);
        run_op(OP_ACC_ADD, 8'hFF, 8'd10, mk(8'd10, 0, 0, 0, 8'd10), 0);
        run_op(OP_ACC_ADD, 8'hFF, 8'd20, mk(8'd30, 0, 0, 0, 8'd30), 0);
        run_op(OP_ACC_SUB, 8'hFF, 8'd5,  mk(8'd25, 0, 0, 0, 8'd25), 0);

        run_op(OP_ADD, 8'd3, 8'd4, mk(8'd7, 0, 0, 0, 8'd25), 6);

        op = OP_ADD; A = 8'd1; B = 8'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_acc",       32'(acc),       32'd0);
        chk("midrst_S",         32'(S),         32'd0);

        run_op(OP_ACC_SUB, 8'h55, 8'd1, mk(8'hFF, 1, 0, 0, 8'hFF), 0);
        m_acc = 8'hFF;

        for (int i = 0; i < 40; i++)
            rand_op(($urandom_range(0, 1) == 1) ? OP_SUB : OP_ADD,
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
